// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC clock-monitor block: FSM state encoding and the
// result record (overflow flag + saturating edge count).
`ifndef BSG_DMC_PKG_SV
`define BSG_DMC_PKG_SV

// Result record; count width follows the instantiating block's count_width_p.
`define BSG_DMC_CLK_MON_RESULT_S(cw) struct packed { logic overflow; logic [(cw)-1:0] count; }

package bsg_dmc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      HOLD    = 2'd3
   } bsg_dmc_clk_mon_state_e;

endpackage

`endif

// File: rtl/bsg_sync_sync.sv
// Multi-flop synchronizer for signals arriving from an unrelated clock.
// All stages clear asynchronously on reset.
module bsg_sync_sync #(
   parameter int width_p  = 1,
   parameter int stages_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   logic [stages_p*width_p-1:0] chain_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[(stages_p-1)*width_p-1:0], d_i};
      end
   end

   assign q_o = chain_q[stages_p*width_p-1 -: width_p];

endmodule

// File: rtl/bsg_dmc_clk_monitor.sv
// Clock monitor: counts rising edges of the downsampled DFI monitor clock over
// a programmable window of clk_i cycles and presents the result with a
// valid/ready handshake.
//
// Handshake: v_o is a registered function of the FSM state only (HOLD). A
// result transfers on any clk_i edge where v_o & ready_i; count_o and
// overflow_o stay constant while v_o is high and only change on entry to HOLD.
module bsg_dmc_clk_monitor
   import bsg_dmc_pkg::*;
#(
   parameter int window_width_p = 16,
   parameter int count_width_p  = 16,
   parameter int sync_stages_p  = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      mon_clk_i,
   input  logic                      en_i,
   input  logic [window_width_p-1:0] window_i,
   output logic                      v_o,
   input  logic                      ready_i,
   output logic [count_width_p-1:0]  count_o,
   output logic                      overflow_o,
   output bsg_dmc_clk_mon_state_e    state_o
);

   typedef `BSG_DMC_CLK_MON_RESULT_S(count_width_p) result_s;

   // One extra bit so a zero window can load 2^window_width_p.
   localparam int win_cnt_w = window_width_p + 1;
   localparam logic [win_cnt_w-1:0] win_full = {1'b1, {window_width_p{1'b0}}};
   localparam logic [win_cnt_w-1:0] win_one  = {{window_width_p{1'b0}}, 1'b1};
   localparam logic [count_width_p-1:0] count_max = '1;

   // Edge detection. The edge becomes visible combinationally once the new
   // level leaves the synchronizer and acts on the following clk_i edge, so a
   // mon_clk_i transition takes effect sync_stages_p+1 cycles later.
   logic mon_sync;
   logic hist_q;
   logic edge_det;

   bsg_sync_sync #(
      .width_p  (1),
      .stages_p (sync_stages_p)
   ) sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (mon_clk_i),
      .q_o     (mon_sync)
   );

   // History flop: previous synchronized level.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) hist_q <= 1'b0;
      else         hist_q <= mon_sync;
   end

   assign edge_det = mon_sync & ~hist_q;

   bsg_dmc_clk_mon_state_e     state_q, state_d;
   logic [win_cnt_w-1:0]       win_q, win_d;
   logic [count_width_p-1:0]   cnt_q, cnt_d;
   logic                       ovf_q, ovf_d;
   result_s                    res_q, res_d;
   logic [count_width_p-1:0]   cnt_inc;
   logic                       ovf_inc;

   // Saturating count update for this cycle's edge.
   always_comb begin
      cnt_inc = cnt_q;
      ovf_inc = ovf_q;
      if (edge_det) begin
         if (cnt_q == count_max) ovf_inc = 1'b1;
         else                    cnt_inc = cnt_q + 1'b1;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (en_i) state_d = ARM;
         end
         ARM: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (edge_det) begin
               // The aligning edge starts the window but is not counted.
               win_d   = (window_i == '0) ? win_full : {1'b0, window_i};
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!en_i) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
               ovf_d = ovf_inc;
               win_d = win_q - win_one;
               if (win_q == win_one) begin
                  // Last sampling cycle: its edge is part of the result.
                  res_d.count    = cnt_inc;
                  res_d.overflow = ovf_inc;
                  state_d        = HOLD;
               end
            end
         end
         HOLD: begin
            if (ready_i) state_d = en_i ? ARM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, window counter, running count and result registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
      end
   end

   assign v_o        = (state_q == HOLD);
   assign count_o    = res_q.count;
   assign overflow_o = res_q.overflow;
   assign state_o    = state_q;

endmodule

// File: tb/tb_bsg_dmc_clk_monitor.sv
// Bench for bsg_dmc_clk_monitor: three instances (default, narrow window,
// narrow count), a table of directed measurements, and hand sequences for
// result hold, abort and reset during HOLD.
module tb_bsg_dmc_clk_monitor;
  import bsg_dmc_pkg::*;

  typedef struct {
    int dut;
    int period;
    int window;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        mon [3];
  logic        en  [3];
  logic        rdy [3];
  int          per [3] = '{0, 0, 0};
  int          gcnt[3];
  logic [15:0] win0;
  logic [3:0]  win1;
  logic [15:0] win2;
  logic        v   [3];
  logic        ovf [3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  bsg_dmc_clk_mon_state_e st[3];

  bsg_dmc_clk_monitor dut0 (
    .clk_i(clk), .reset_i(rst), .mon_clk_i(mon[0]), .en_i(en[0]),
    .window_i(win0), .v_o(v[0]), .ready_i(rdy[0]), .count_o(cnt0),
    .overflow_o(ovf[0]), .state_o(st[0]));

  bsg_dmc_clk_monitor #(.window_width_p(4)) dut1 (
    .clk_i(clk), .reset_i(rst), .mon_clk_i(mon[1]), .en_i(en[1]),
    .window_i(win1), .v_o(v[1]), .ready_i(rdy[1]), .count_o(cnt1),
    .overflow_o(ovf[1]), .state_o(st[1]));

  bsg_dmc_clk_monitor #(.count_width_p(4)) dut2 (
    .clk_i(clk), .reset_i(rst), .mon_clk_i(mon[2]), .en_i(en[2]),
    .window_i(win2), .v_o(v[2]), .ready_i(rdy[2]), .count_o(cnt2),
    .overflow_o(ovf[2]), .state_o(st[2]));

  // Monitor-clock generators: period per[k] clk cycles, 0 = held low.
  initial begin
    for (int k = 0; k < 3; k++) begin
      mon[k]  = 1'b0;
      gcnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (per[k] == 0) begin
          mon[k]  = 1'b0;
          gcnt[k] = 0;
        end else begin
          gcnt[k]++;
          if (gcnt[k] >= per[k] / 2) begin
            gcnt[k] = 0;
            mon[k]  = ~mon[k];
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      default: return {12'b0, cnt2};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_win(input int i, input int w);
    case (i)
      0:       win0 = w[15:0];
      1:       win1 = w[3:0];
      default: win2 = w[15:0];
    endcase
  endtask

  task automatic wait_v(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (v[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input int i, input bsg_dmc_clk_mon_state_e s,
                            input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (st[i] == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Enable, wait for the result, check it, then accept with en dropped.
  task automatic measure_and_accept(input int i, input int exp_cnt, input int exp_ovf,
                                    input string name);
    bit ok;
    en[i] = 1'b1;
    wait_v(i, 3000, ok);
    check({name, "_v_timeout"}, {31'b0, ok}, 1);
    check({name, "_count"}, {16'b0, get_cnt(i)}, exp_cnt);
    check({name, "_overflow"}, {31'b0, ovf[i]}, exp_ovf);
    rdy[i] = 1'b1;
    en[i]  = 1'b0;
    @(negedge clk);
    rdy[i] = 1'b0;
    check({name, "_v_drop"}, {31'b0, v[i]}, 0);
    check({name, "_idle"}, st[i], IDLE);
  endtask

  // Program a period/window while idle and let the generator settle.
  task automatic setup(input int i, input int period, input int window);
    per[i] = period;
    set_win(i, window);
    repeat (2 * period + 4) @(negedge clk);
  endtask

  // ---------------- test ----------------
  vec_t vecs[11];

  initial begin
    bit ok;
    bit seen_v;

    vecs[0]  = '{0, 8, 64, 8, 0};
    vecs[1]  = '{0, 4, 20, 5, 0};
    vecs[2]  = '{0, 2, 10, 5, 0};
    vecs[3]  = '{0, 6, 1, 0, 0};
    vecs[4]  = '{0, 6, 6, 1, 0};
    vecs[5]  = '{1, 4, 0, 4, 0};
    vecs[6]  = '{1, 4, 15, 3, 0};
    vecs[7]  = '{2, 2, 64, 15, 1};
    vecs[8]  = '{2, 2, 30, 15, 0};
    vecs[9]  = '{2, 2, 32, 15, 1};
    vecs[10] = '{2, 8, 64, 8, 0};

    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      rdy[k] = 1'b0;
    end
    win0 = 16'd64;
    win1 = 4'd0;
    win2 = 16'd64;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_v%0d", k), {31'b0, v[k]}, 0);
      check($sformatf("reset_count%0d", k), {16'b0, get_cnt(k)}, 0);
      check($sformatf("reset_overflow%0d", k), {31'b0, ovf[k]}, 0);
      check($sformatf("reset_state%0d", k), st[k], IDLE);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table-driven measurements
    for (int n = 0; n < 11; n++) begin
      setup(vecs[n].dut, vecs[n].period, vecs[n].window);
      measure_and_accept(vecs[n].dut, vecs[n].exp_cnt, vecs[n].exp_ovf,
                         $sformatf("vec%0d", n));
    end

    // Result held with ready low; window change mid-measure ignored; re-arm
    setup(0, 8, 64);
    en[0] = 1'b1;
    wait_state(0, MEASURE, 200, ok);
    check("hold_reach_measure", {31'b0, ok}, 1);
    win0 = 16'd5;
    wait_v(0, 3000, ok);
    check("hold_v_timeout", {31'b0, ok}, 1);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold_v_c%0d", c), {31'b0, v[0]}, 1);
      check($sformatf("hold_count_c%0d", c), {16'b0, cnt0}, 8);
      check($sformatf("hold_overflow_c%0d", c), {31'b0, ovf[0]}, 0);
      @(negedge clk);
    end
    win0 = 16'd64;
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("rearm_v_drop", {31'b0, v[0]}, 0);
    check("rearm_state", st[0], ARM);
    measure_and_accept(0, 8, 0, "rearm");

    // Abort at MEASURE cycle 20 of 64
    setup(0, 8, 64);
    en[0] = 1'b1;
    wait_state(0, MEASURE, 200, ok);
    check("abort_reach_measure", {31'b0, ok}, 1);
    repeat (19) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    check("abort_idle", st[0], IDLE);
    seen_v = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (v[0] === 1'b1) seen_v = 1'b1;
      @(negedge clk);
    end
    check("abort_no_v", {31'b0, seen_v}, 0);
    measure_and_accept(0, 8, 0, "after_abort");

    // Reset pulsed during HOLD
    setup(0, 8, 64);
    en[0] = 1'b1;
    wait_v(0, 3000, ok);
    check("rst_hold_v_timeout", {31'b0, ok}, 1);
    check("rst_hold_count_before", {16'b0, cnt0}, 8);
    rst = 1'b1;
    #1;
    check("rst_hold_v", {31'b0, v[0]}, 0);
    check("rst_hold_count", {16'b0, cnt0}, 0);
    check("rst_hold_overflow", {31'b0, ovf[0]}, 0);
    check("rst_hold_state", st[0], IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_and_accept(0, 8, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_dmc_clk_monitor.md
BSG_DMC_CLK_MONITOR -- requirements
Module: bsg_dmc_clk_monitor

Interface
REQ-001 Parameter window_width_p, default 16: width of the measurement window length, in clk_i cycles.
REQ-002 Parameter count_width_p, default 16: width of the edge count result.
REQ-003 Parameter sync_stages_p, default 2: number of synchronizer flops on mon_clk_i (legal values 2 or 3).
REQ-004 Port clk_i, input, 1: core/tag-side clock; the block's only clock.
REQ-005 Port reset_i, input, 1: asynchronous, active-high reset.
REQ-006 Port mon_clk_i, input, 1: downsampled DFI clock-monitor output; asynchronous to clk_i and treated as data.
REQ-007 Port en_i, input, 1: measurement enable (level).
REQ-008 Port window_i, input, window_width_p: window length in clk_i cycles; a value of 0 means 2^window_width_p.
REQ-009 Port v_o, output, 1: result valid.
REQ-010 Port ready_i, input, 1: consumer accepts the result.
REQ-011 Port count_o, output, count_width_p: number of mon_clk_i rising edges seen in the window.
REQ-012 Port overflow_o, output, 1: the count saturated during the window.

Function
REQ-013 mon_clk_i SHALL pass through a sync_stages_p-flop synchronizer, then one history flop; a rising edge is detected as sync=1 and history=0.
REQ-014 Edge-detect latency SHALL be sync_stages_p+1 clk_i cycles from the mon_clk_i transition.
REQ-015 The FSM SHALL have the states IDLE, ARM, MEASURE and HOLD.
REQ-016 IDLE: if en_i=1, go to ARM; otherwise stay in IDLE.
REQ-017 ARM: on the first detected edge, load the window counter from window_i (0 loads 2^window_width_p), clear the count and overflow, and go to MEASURE; the aligning edge is not counted.
REQ-018 MEASURE: the window counter SHALL decrement every cycle, and the edge count SHALL increment on every detected edge.
REQ-019 The edge count SHALL saturate at 2^count_width_p-1; an edge arriving while the count is saturated SHALL set the overflow flag.
REQ-020 MEASURE exit: on the cycle the window counter equals 1, the edge of that cycle SHALL be included, the result registers SHALL be latched, and the FSM SHALL go to HOLD.
REQ-021 Window length SHALL be exactly N clk_i cycles of edge sampling for window_i=N.
REQ-022 HOLD: v_o=1, with count_o and overflow_o stable.
REQ-023 HOLD on v_o & ready_i: go to ARM if en_i=1, else to IDLE; v_o SHALL drop the next cycle.
REQ-024 en_i=0 while in ARM or MEASURE SHALL abort to IDLE the next cycle with no v_o pulse, and the partial count SHALL be discarded.
REQ-025 en_i=0 while in HOLD SHALL NOT drop the result; the result remains until accepted.
REQ-026 window_i and en_i changes during MEASURE (other than the abort case) SHALL be ignored.
REQ-027 ready_i outside HOLD SHALL be ignored; v_o SHALL NOT depend combinationally on ready_i.
REQ-028 count_o and overflow_o SHALL be driven only from the result registers and SHALL change only on entry to HOLD.

Reset
REQ-029 reset_i assertion SHALL immediately force state=IDLE, v_o=0, count_o=0, overflow_o=0, and the window counter, count, synchronizer and history flops to 0.
REQ-030 Reset mid-MEASURE or mid-HOLD SHALL discard all results; after deassertion the block behaves as from power-up.
REQ-031 Reset deassertion is synchronized externally to clk_i; the block SHALL NOT add a deassertion synchronizer.

Structure
REQ-032 bsg_dmc_pkg SHALL hold the bsg_dmc_clk_mon_state_e enum (IDLE, ARM, MEASURE, HOLD).
REQ-033 bsg_dmc_pkg SHALL hold a result struct {overflow, count} parameterized by a macro on count_width_p.
REQ-034 The synchronizer SHALL be the single sub-module instance: bsg_sync_sync (width 1).
REQ-035 The block SHALL attach to clock_monitor_clk_o of the DMC clock/reset generator.

Verification
REQ-036 sync_stages_p=2, mon_clk_i period 8 clk_i cycles, window_i=64, en_i=1 -> v_o=1 with count_o=8, overflow_o=0.
REQ-037 window_width_p=4, window_i=0, mon period 4 clk_i cycles -> window of 16 cycles, count_o=4.
REQ-038 count_width_p=4, mon period 2 clk_i cycles, window_i=64 -> count_o=15, overflow_o=1.
REQ-039 Result ready, ready_i held low 10 cycles, then high -> v_o, count_o and overflow_o stable for all 10 cycles; v_o=0 the cycle after the handshake; en_i=1 re-arms.
REQ-040 en_i dropped at MEASURE cycle 20 of 64 -> IDLE next cycle, v_o never asserts; re-enable yields a full fresh measurement.
REQ-041 reset_i pulsed during HOLD -> v_o=0, count_o=0, overflow_o=0 asynchronously; with en_i=1 after release, a fresh measurement completes.
